// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan driver with PWM brightness, blink and
// frame-synchronous double buffering. din_vld is a valid-only strobe (no ready): every strobe is taken.
module seg_scan_ctrl #(
   parameter int DIG_NUM      = 6,
   parameter int TIME_SCAN    = 25_000,
   parameter int BLINK_FRAMES = 50
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [8*DIG_NUM-1:0]   din,
   input  logic                   din_vld,
   input  logic [DIG_NUM-1:0]     din_mask,
   input  logic [DIG_NUM-1:0]     din_dp,
   input  logic [DIG_NUM-1:0]     din_blink,
   input  logic [3:0]             bright,
   output logic [DIG_NUM-1:0]     sel,
   output logic [7:0]             dig,
   output logic                   frame_done
);

   localparam int CW = $clog2(TIME_SCAN);
   localparam int IW = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int OW = CW + 5;

   typedef struct packed {
      logic [8*DIG_NUM-1:0] data;
      logic [DIG_NUM-1:0]   mask;
      logic [DIG_NUM-1:0]   dp;
      logic [DIG_NUM-1:0]   blink;
      logic [3:0]           bright;
   } cfg_t;

   localparam cfg_t CFG_RST = '{data: '0, mask: '0, dp: '0, blink: '0, bright: 4'hF};

   logic [CW-1:0]      cnt_scan, cnt_nxt;
   logic [IW-1:0]      idx, idx_nxt;
   logic [BW-1:0]      blink_cnt, bcnt_nxt;
   logic               blink_ph, ph_nxt;
   logic               pending;
   cfg_t               act, shd, act_nxt, live;
   logic               slot_end, fb, blink_wrap;
   logic [OW-1:0]      on_time;
   logic [7:0]         glyph;
   logic               lit;
   logic [DIG_NUM-1:0] sel_d;
   logic [7:0]         dig_d;

   function automatic logic [6:0] decode(input logic [7:0] code);
      case (code)
         8'd0:    decode = 7'h40;
         8'd1:    decode = 7'h79;
         8'd2:    decode = 7'h24;
         8'd3:    decode = 7'h30;
         8'd4:    decode = 7'h19;
         8'd5:    decode = 7'h12;
         8'd6:    decode = 7'h02;
         8'd7:    decode = 7'h78;
         8'd8:    decode = 7'h00;
         8'd9:    decode = 7'h10;
         8'd10:   decode = 7'h08;
         8'd11:   decode = 7'h03;
         8'd12:   decode = 7'h46;
         8'd13:   decode = 7'h21;
         8'd14:   decode = 7'h06;
         8'd15:   decode = 7'h0E;
         8'h52:   decode = 7'h2F;  // 'R' -> r
         8'h44:   decode = 7'h21;  // 'D' -> d
         8'h50:   decode = 7'h0C;  // 'P'
         8'h4E:   decode = 7'h2B;  // 'N' -> n
         8'h53:   decode = 7'h12;  // 'S'
         default: decode = 7'h7F;
      endcase
   endfunction

   // Next-state of the scan position; outputs are registered from these so that
   // frame_done, the new active config and digit 0 all appear on the same edge.
   always_comb begin
      slot_end   = (cnt_scan == CW'(TIME_SCAN - 1));
      fb         = slot_end && (idx == IW'(DIG_NUM - 1));
      cnt_nxt    = slot_end ? '0 : cnt_scan + 1'b1;
      idx_nxt    = fb ? '0 : (slot_end ? idx + 1'b1 : idx);
      blink_wrap = fb && (blink_cnt == BW'(BLINK_FRAMES - 1));
      bcnt_nxt   = !fb ? blink_cnt : (blink_wrap ? '0 : blink_cnt + 1'b1);
      ph_nxt     = blink_ph ^ blink_wrap;
      live       = '{data: din, mask: din_mask, dp: din_dp, blink: din_blink, bright: bright};
      act_nxt    = act;
      if (fb && (pending || din_vld))
         act_nxt = din_vld ? live : shd;
   end

   always_comb begin
      on_time = ((OW'(act_nxt.bright) + OW'(1)) * OW'(TIME_SCAN)) >> 4;
      glyph   = act_nxt.data[32'(idx_nxt)*8 +: 8];
      lit     = !act_nxt.mask[idx_nxt] && !(act_nxt.blink[idx_nxt] && ph_nxt) &&
                ({{(OW-CW){1'b0}}, cnt_nxt} < on_time);
      sel_d   = '1;
      dig_d   = 8'hFF;
      if (lit) begin
         sel_d = ~(DIG_NUM'(1) << idx_nxt);
         dig_d = {~act_nxt.dp[idx_nxt], decode(glyph)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_scan   <= '0;
         idx        <= '0;
         blink_cnt  <= '0;
         blink_ph   <= 1'b0;
         pending    <= 1'b0;
         act        <= CFG_RST;
         shd        <= CFG_RST;
         sel        <= '1;
         dig        <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         cnt_scan   <= cnt_nxt;
         idx        <= idx_nxt;
         blink_cnt  <= bcnt_nxt;
         blink_ph   <= ph_nxt;
         pending    <= fb ? 1'b0 : (pending | din_vld);
         act        <= act_nxt;
         if (din_vld)
            shd <= live;
         sel        <= sel_d;
         dig        <= dig_d;
         frame_done <= fb;
      end
   end

endmodule
